// File: rtl/ram_bubble_sort_ctrl_pkg.sv
// Shared definitions for the RAM bubble-sort controller: FSM state encoding
// and the default RAM geometry used by both the controller and the RAM.
package sort_pkg;

  localparam int SORT_ADDR_WDTH = 4;
  localparam int SORT_DATA_WDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    CMP  = 3'd3,
    WR_A = 3'd4,
    WR_B = 3'd5,
    DONE = 3'd6
  } sort_state_t;

endpackage

// File: rtl/ram_bubble_sort_ctrl_if.sv
// Bundle of the sequencer handshake and the single RAM port owned by the
// sort controller. The master side is the controller; the slave side is
// whatever drives start/len and returns RAM read data.
interface ram_bubble_sort_ctrl_if
  import sort_pkg::*;
#(
  parameter int ADDR_WDTH = SORT_ADDR_WDTH,
  parameter int DATA_WDTH = SORT_DATA_WDTH
);

  logic                        start;
  logic [ADDR_WDTH:0]          len;
  logic                        busy;
  logic                        done;
  logic                        ram_wr_enable;
  logic                        ram_rd_enable;
  logic [ADDR_WDTH-1:0]        ram_address;
  logic signed [DATA_WDTH-1:0] ram_wr_data;
  logic signed [DATA_WDTH-1:0] ram_rd_data;

  modport master (
    input  start, len, ram_rd_data,
    output busy, done, ram_wr_enable, ram_rd_enable, ram_address, ram_wr_data
  );

  modport slave (
    output start, len, ram_rd_data,
    input  busy, done, ram_wr_enable, ram_rd_enable, ram_address, ram_wr_data
  );

endinterface

// File: rtl/ram_bubble_sort_ctrl.sv
// In-place ascending signed bubble sort of the first len words of a
// single-port synchronous-read RAM. Each pair costs RD_A, RD_B, CMP and,
// when out of order, WR_A and WR_B. All outputs decode from registered
// state so there is no combinational path from inputs to outputs.
// Optional build macro SORT_EARLY_EXIT_EN: finish as soon as a whole pass
// completes without any swap instead of always running len-1 passes.
module ram_bubble_sort_ctrl
  import sort_pkg::*;
#(
  parameter int ADDR_WDTH = SORT_ADDR_WDTH,
  parameter int DATA_WDTH = SORT_DATA_WDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ram_bubble_sort_ctrl_if.master bus
);

  sort_state_t                 state_q, state_d;
  logic [ADDR_WDTH:0]          limit_q, limit_d;
  logic [ADDR_WDTH-1:0]        i_q, i_d;
  logic signed [DATA_WDTH-1:0] reg_a_q, reg_a_d;
  logic signed [DATA_WDTH-1:0] reg_b_q, reg_b_d;
  logic                        swapped_q, swapped_d;

  // Address of the second element of the pair; never wraps because the
  // largest i is len-2.
  logic [ADDR_WDTH-1:0]        i_plus1;
  // Same value widened to compare against the pass limit.
  logic [ADDR_WDTH:0]          i_plus1_ext;
  logic                        advance;
  logic                        last_pass;

  assign i_plus1     = i_q + ADDR_WDTH'(1);
  assign i_plus1_ext = {1'b0, i_q} + (ADDR_WDTH + 1)'(1);

`ifdef SORT_EARLY_EXIT_EN
  assign last_pass = (limit_q == (ADDR_WDTH + 1)'(1)) || !swapped_q;
`else
  assign last_pass = (limit_q == (ADDR_WDTH + 1)'(1));
`endif

  // State and datapath registers; reset returns everything to an idle zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      limit_q   <= '0;
      i_q       <= '0;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      i_q       <= i_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      swapped_q <= swapped_d;
    end
  end

  // Next-state and datapath update, including the end-of-pair advance step.
  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    i_d       = i_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    swapped_d = swapped_q;
    advance   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len >= (ADDR_WDTH + 1)'(2)) begin
            limit_d   = bus.len - (ADDR_WDTH + 1)'(1);
            i_d       = '0;
            swapped_d = 1'b0;
            state_d   = RD_A;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        reg_a_d = bus.ram_rd_data;
        state_d = CMP;
      end
      CMP: begin
        reg_b_d = bus.ram_rd_data;
        if (bus.ram_rd_data < reg_a_q) begin
          swapped_d = 1'b1;
          state_d   = WR_A;
        end else begin
          advance = 1'b1;
        end
      end
      WR_A: state_d = WR_B;
      WR_B: advance = 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (i_plus1_ext < limit_q) begin
        i_d     = i_plus1;
        state_d = RD_A;
      end else if (last_pass) begin
        state_d = DONE;
      end else begin
        limit_d   = limit_q - (ADDR_WDTH + 1)'(1);
        i_d       = '0;
        swapped_d = 1'b0;
        state_d   = RD_A;
      end
    end
  end

  // Output decode from the registered state only; at most one strobe active.
  always_comb begin
    bus.busy          = (state_q != IDLE);
    bus.done          = (state_q == DONE);
    bus.ram_wr_enable = 1'b0;
    bus.ram_rd_enable = 1'b0;
    bus.ram_address   = '0;
    bus.ram_wr_data   = '0;
    case (state_q)
      RD_A: begin
        bus.ram_rd_enable = 1'b1;
        bus.ram_address   = i_q;
      end
      RD_B: begin
        bus.ram_rd_enable = 1'b1;
        bus.ram_address   = i_plus1;
      end
      WR_A: begin
        bus.ram_wr_enable = 1'b1;
        bus.ram_address   = i_q;
        bus.ram_wr_data   = reg_b_q;
      end
      WR_B: begin
        bus.ram_wr_enable = 1'b1;
        bus.ram_address   = i_plus1;
        bus.ram_wr_data   = reg_a_q;
      end
      default: begin
        bus.ram_wr_enable = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_bubble_sort_ctrl.sv
// Directed self-checking bench for ram_bubble_sort_ctrl. A behavioural
// synchronous-read RAM sits beside the controller and is muxed to a simple
// loader whenever the controller is not busy.
module tb_ram_bubble_sort_ctrl;
  import sort_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;

  logic clk;
  logic rst_n;

  ram_bubble_sort_ctrl_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW)) bus ();

  ram_bubble_sort_ctrl #(.ADDR_WDTH(AW), .DATA_WDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic signed [DW-1:0] mem [16];
  logic                 ld_we;
  logic [AW-1:0]        ld_addr;
  logic signed [DW-1:0] ld_data;

  logic                 ram_we;
  logic                 ram_re;
  logic [AW-1:0]        ram_addr;
  logic signed [DW-1:0] ram_wdata;

  int wr_total;
  int rd_total;
  int overlap_total;
  int checks;
  int failures;

  assign ram_we    = bus.busy ? bus.ram_wr_enable : ld_we;
  assign ram_re    = bus.busy ? bus.ram_rd_enable : 1'b0;
  assign ram_addr  = bus.busy ? bus.ram_address   : ld_addr;
  assign ram_wdata = bus.busy ? bus.ram_wr_data   : ld_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) bus.ram_rd_data <= mem[ram_addr];
  end

  // Free-running strobe counters; tests take differences of snapshots.
  always @(posedge clk) begin
    if (bus.ram_wr_enable) wr_total <= wr_total + 1;
    if (bus.ram_rd_enable) rd_total <= rd_total + 1;
    if (bus.ram_wr_enable && bus.ram_rd_enable) overlap_total <= overlap_total + 1;
  end

  initial begin
    wr_total      = 0;
    rd_total      = 0;
    overlap_total = 0;
  end

  task automatic check_output(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic load_word(input int a, input int d);
    @(negedge clk);
    ld_we   = 1'b1;
    ld_addr = AW'(a);
    ld_data = DW'(d);
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  // Start a sort and count cycles until done; cycle 1 follows the start edge.
  // A one-cycle start pulse with len=0 is injected at cycle pulse_at (if >0).
  task automatic apply_stimulus(input int n, input int pulse_at, output int cycles);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = (AW + 1)'(n);
    @(posedge clk);
    #1 bus.start = 1'b0;
    cycles = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (c == pulse_at) begin
        bus.start = 1'b1;
        bus.len   = '0;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        cycles = c;
        break;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    check_output("busy_after_done", bus.busy, 0);
    check_output("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    int cyc;
    int wr0;
    int rd0;
    int exp5 [5];
    int exp4 [4];

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.len   = '0;
    ld_we     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;

    #2;
    check_output("reset_busy", bus.busy, 0);
    check_output("reset_done", bus.done, 0);
    check_output("reset_wr", bus.ram_wr_enable, 0);
    check_output("reset_rd", bus.ram_rd_enable, 0);
    check_output("reset_addr", bus.ram_address, 0);
    check_output("reset_wdata", bus.ram_wr_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // len=2, step-by-step sequence
    load_word(0, 5);
    load_word(1, 3);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = (AW + 1)'(2);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check_output("l2_c1_rd", bus.ram_rd_enable, 1);
    check_output("l2_c1_addr", bus.ram_address, 0);
    @(negedge clk);
    check_output("l2_c2_rd", bus.ram_rd_enable, 1);
    check_output("l2_c2_addr", bus.ram_address, 1);
    @(negedge clk);
    check_output("l2_c3_strobes", {bus.ram_rd_enable, bus.ram_wr_enable}, 0);
    check_output("l2_c3_busy", bus.busy, 1);
    @(negedge clk);
    check_output("l2_c4_wr", bus.ram_wr_enable, 1);
    check_output("l2_c4_addr", bus.ram_address, 0);
    check_output("l2_c4_data", bus.ram_wr_data, 3);
    @(negedge clk);
    check_output("l2_c5_wr", bus.ram_wr_enable, 1);
    check_output("l2_c5_addr", bus.ram_address, 1);
    check_output("l2_c5_data", bus.ram_wr_data, 5);
    @(negedge clk);
    check_output("l2_c6_done", bus.done, 1);
    check_output("l2_c6_busy", bus.busy, 1);
    @(negedge clk);
    check_output("l2_c7_idle", bus.busy, 0);
    check_output("l2_mem0", mem[0], 3);
    check_output("l2_mem1", mem[1], 5);

    // len=16 reverse sorted: every compare swaps
    for (int k = 0; k < 16; k++) load_word(k, 15 - k);
    wr0 = wr_total;
    apply_stimulus(16, 0, cyc);
    check_output("rev_cycles", cyc, 601);
    check_output("rev_writes", wr_total - wr0, 240);
    for (int k = 0; k < 16; k++) check_output("rev_mem", mem[k], k);

    // len=16 already ascending: no writes
    wr0 = wr_total;
    apply_stimulus(16, 0, cyc);
`ifdef SORT_EARLY_EXIT_EN
    check_output("asc_cycles", cyc, 46);
`else
    check_output("asc_cycles", cyc, 361);
`endif
    check_output("asc_writes", wr_total - wr0, 0);

    // Signed values with duplicates, plus a start pulse while busy
    load_word(0, -1);
    load_word(1, 7);
    load_word(2, -8);
    load_word(3, 7);
    load_word(4, 0);
    load_word(5, 100);
    exp5 = '{-8, -1, 0, 7, 7};
    wr0 = wr_total;
    apply_stimulus(5, 4, cyc);
`ifdef SORT_EARLY_EXIT_EN
    check_output("sgn_cycles", cyc, 36);
`else
    check_output("sgn_cycles", cyc, 39);
`endif
    check_output("sgn_writes", wr_total - wr0, 8);
    for (int k = 0; k < 5; k++) check_output("sgn_mem", mem[k], exp5[k]);
    check_output("sgn_untouched", mem[5], 100);

    // len=0 and len=1 finish immediately without RAM traffic
    wr0 = wr_total;
    rd0 = rd_total;
    apply_stimulus(0, 0, cyc);
    check_output("len0_cycles", cyc, 1);
    apply_stimulus(1, 0, cyc);
    check_output("len1_cycles", cyc, 1);
    check_output("len01_strobes", (wr_total - wr0) + (rd_total - rd0), 0);

    // Reset in the middle of WR_A
    for (int k = 0; k < 4; k++) load_word(k, 4 - k);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = (AW + 1)'(4);
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (bus.ram_wr_enable) begin
        cyc = c;
        break;
      end
    end
    check_output("rst_reached_wra", cyc, 4);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_wr", bus.ram_wr_enable, 0);
    check_output("rst_rd", bus.ram_rd_enable, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_done", bus.done, 0);
    check_output("rst_addr", bus.ram_address, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_idle", bus.busy, 0);

    // Fresh sort after reset
    load_word(0, 9);
    load_word(1, -3);
    load_word(2, 4);
    load_word(3, 0);
    exp4 = '{-3, 0, 4, 9};
    apply_stimulus(4, 0, cyc);
    check_output("post_done_seen", cyc > 0, 1);
    for (int k = 0; k < 4; k++) check_output("post_mem", mem[k], exp4[k]);

    check_output("rd_wr_overlap", overlap_total, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bubble_sort_ctrl.md
Name: ram_bubble_sort_ctrl

Overview:
- In-place ascending signed bubble sort of the first len words of a single-port, synchronous-read RAM.
- Sits beside the RAM in the sort top level and owns its only port while busy.
- Top level muxes the RAM port to the loader when busy=0.
- Start/done handshake to the system sequencer.

Parameters:
ADDR_WDTH, 4, RAM address width; depth 2**ADDR_WDTH.
DATA_WDTH, 32, RAM word width; contents are signed two's complement.

Ports:
clk  input  1  clock
rst_n  input  1  reset
start  input  1  sort request, sampled only in IDLE
len  input  ADDR_WDTH+1  number of words to sort (0..2**ADDR_WDTH), latched on accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on completion
ram_wr_enable  output  1  RAM write strobe
ram_rd_enable  output  1  RAM read strobe
ram_address  output  ADDR_WDTH  RAM address
ram_wr_data  output  DATA_WDTH  RAM write data (signed)
ram_rd_data  input  DATA_WDTH  RAM read data (signed); valid the cycle after ram_rd_enable

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset forces IDLE, clears internal registers, and drives all outputs to 0.
- Outputs are decoded from registered state only; no input-to-output combinational path.
- At most one of rd/wr is asserted per cycle.
- Registers: limit (compares in current pass), index i, reg_a, reg_b, swapped flag.

State machine:
- IDLE: all outputs 0.
  - start & len>=2: latch limit=len-1, i=0, swapped=0; go RD_A.
  - start & len<2: go DONE without touching the RAM.
  - start is ignored outside IDLE.
- RD_A: rd_enable=1, address=i.
- RD_B: rd_enable=1, address=i+1; capture reg_a=ram_rd_data.
- CMP: capture reg_b=ram_rd_data.
  - If reg_b < reg_a (signed): set swapped; go WR_A.
  - Otherwise take the ADVANCE action.
  - Equal values are never swapped.
- WR_A: wr_enable=1, address=i, wr_data=reg_b.
- WR_B: wr_enable=1, address=i+1, wr_data=reg_a; then ADVANCE.
- ADVANCE (transition action, not a state):
  - If i+1<limit: i++, go RD_A.
  - Else (end of pass): if limit==1, go DONE; otherwise limit--, i=0, swapped=0, go RD_A.
- DONE: done=1, busy=1 for exactly one cycle; then IDLE.

Timing:
- Non-swapping pair costs 3 cycles; swapping pair costs 5 cycles.
- start accepted at edge k puts RD_A in cycle k+1.

Boundaries:
- len=2**ADDR_WDTH: the i+1 address must not wrap; max i+1 = len-1.
- Reset mid-sort: abort immediately; ram_wr_enable drops asynchronously. RAM contents are an unspecified permutation of the original (a swap may be half written).

Optional Feature:
- Macro: SORT_EARLY_EXIT_EN.
- Defined: at end of pass, if swapped==0, go DONE regardless of limit.
- Undefined: always run all len-1 passes.
- Either way the final RAM contents are identical; only the cycle count differs.

Decomposition:
- Package sort_pkg holds:
  - state enum/localparams (IDLE, RD_A, RD_B, CMP, WR_A, WR_B, DONE);
  - default ADDR_WDTH/DATA_WDTH constants shared with the RAM.
- No sub-module: the FSM and datapath are a single module.
- RAM is instantiated beside the controller in the top level, not inside it.

Test Plan:
- len=2, RAM[0]=5, RAM[1]=3, start at edge 0:
  - cycles 1..5 are RD_A, RD_B, CMP, WR_A, WR_B; done=1 in cycle 6;
  - RAM[0]=3, RAM[1]=5.
- len=16, reverse sorted 15..0: all 120 compares swap; done in cycle 601 after start; RAM ascending 0..15. Same with or without the macro.
- len=16, already ascending:
  - with SORT_EARLY_EXIT_EN: done in cycle 46, zero writes;
  - without: done in cycle 361, zero writes.
- Signed and duplicate values, len=5 [-1, 7, -8, 7, 0] -> [-8, -1, 0, 7, 7]; the two 7s are never swapped with each other.
- len=0 and len=1: done pulses the cycle after start, no RAM strobes. start pulsed while busy has no effect.
- rst_n low mid-WR_A: all outputs 0 immediately; after release busy=0. A fresh start with len=4 sorts correctly.
